// File: rtl/pusher_chain_pkg.sv
// Shared types and default sizing for the pusher chain flow controller.
package pusher_chain_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int WIDTH_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/pusher_chain_sched_if.sv
// Handshake, control and status bundle between the chain environment and its scheduler.
interface pusher_chain_sched_if
    import pusher_chain_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             hold;
    logic             flush;
    logic             flush_done;
    logic [DEPTH-1:0] stage_en;
    logic [DEPTH-1:0] stage_valid;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] in_count;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    modport master (
        output in_valid, out_ready, hold, flush,
        input  in_ready, out_valid, flush_done, stage_en, stage_valid,
               occupancy, in_count, out_count, busy
    );

    modport slave (
        input  in_valid, out_ready, hold, flush,
        output in_ready, out_valid, flush_done, stage_en, stage_valid,
               occupancy, in_count, out_count, busy
    );

endinterface

// File: rtl/chain_slot_ctrl.sv
// One chain stage's occupancy bit plus its ready/load-enable terms.
module chain_slot_ctrl (
    input  logic clock,
    input  logic reset,
    input  logic hold,
    input  logic src_valid,
    input  logic ready_next,
    output logic valid,
    output logic ready,
    output logic stage_en
);
    logic valid_q;
    logic valid_d;

    // A stage can take a new item if it is empty or its own item moves on.
    assign ready    = ~valid_q | ready_next;
    assign stage_en = ready & src_valid & ~hold & reset;
    assign valid    = valid_q;

    // Next occupancy: load wins, otherwise release when the item moves downstream.
    always_comb begin
        valid_d = valid_q;
        if (stage_en) begin
            valid_d = 1'b1;
        end else if (valid_q & ready_next & ~hold) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Occupancy register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/pusher_chain_sched.sv
// Flow controller for the pusher shift chain: per-stage enables, handshakes,
// drain/hold sequencing, occupancy and transfer counters.
module pusher_chain_sched
    import pusher_chain_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    pusher_chain_sched_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    sched_state_t     state_q, state_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             flush_done_q, flush_done_d;
    logic [DEPTH-1:0] en_s;
    logic [DEPTH-1:0] valid_s;
    logic             accept_ok_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             flush_eff_s;

    assign accept_ok_s = (state_q != DRAIN);

    // Ready ripples from the output back to the input through per-slot signals.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic ready_s;
        logic ready_nxt_s;
        logic src_s;

        if (i == DEPTH - 1) begin : g_last
            assign ready_nxt_s = bus.out_ready;
        end else begin : g_mid
            assign ready_nxt_s = g_slot[i+1].ready_s;
        end

        if (i == 0) begin : g_first
            assign src_s = bus.in_valid & accept_ok_s;
        end else begin : g_rest
            assign src_s = valid_s[i-1];
        end

        chain_slot_ctrl u_slot (
            .clock      (clock),
            .reset      (reset),
            .hold       (bus.hold),
            .src_valid  (src_s),
            .ready_next (ready_nxt_s),
            .valid      (valid_s[i]),
            .ready      (ready_s),
            .stage_en   (en_s[i])
        );
    end

    assign in_ready_s  = g_slot[0].ready_s & ~bus.hold & accept_ok_s & reset;
    assign out_valid_s = valid_s[DEPTH-1] & ~bus.hold & reset;
    assign in_fire_s   = bus.in_valid & in_ready_s;
    assign out_fire_s  = out_valid_s & bus.out_ready;

    // FSM, counters and flush latch; hold freezes everything but the latch.
    always_comb begin
        state_d      = state_q;
        occ_d        = occ_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        flush_pend_d = flush_pend_q;
        flush_done_d = 1'b0;
        flush_eff_s  = bus.flush | flush_pend_q;
        if (bus.hold) begin
            flush_pend_d = flush_pend_q | bus.flush;
        end else begin
            flush_pend_d = 1'b0;
            occ_d        = occ_q + OCC_W'(in_fire_s) - OCC_W'(out_fire_s);
            in_cnt_d     = in_cnt_q + CNT_W'(in_fire_s);
            out_cnt_d    = out_cnt_q + CNT_W'(out_fire_s);
            case (state_q)
                IDLE: begin
                    // An item taken together with a flush is drained like in RUN.
                    if (flush_eff_s && in_fire_s) begin
                        state_d = DRAIN;
                    end else if (flush_eff_s) begin
                        flush_done_d = 1'b1;
                    end else if (in_fire_s) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (flush_eff_s) begin
                        state_d = DRAIN;
                    end else if (occ_d == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (occ_d == '0) begin
                        state_d      = IDLE;
                        flush_done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            occ_q        <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.stage_en    = en_s;
    assign bus.stage_valid = valid_s;
    assign bus.occupancy   = occ_q;
    assign bus.in_count    = in_cnt_q;
    assign bus.out_count   = out_cnt_q;
    assign bus.flush_done  = flush_done_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pusher_chain_sched.sv
// Self-checking bench: directed scenarios plus random traffic against an item-position model.
module tb_pusher_chain_sched;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    logic clock;
    logic reset;

    pusher_chain_sched_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    pusher_chain_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total;
    int n_bad;
    int done_seen;

    // Model: positions of the items in the chain, front (nearest output) first.
    int               pos_q[$];
    int               nxt_q[$];
    int               m_state;
    bit               m_pend;
    bit               m_done;
    logic [CNT_W-1:0] m_in;
    logic [CNT_W-1:0] m_out;
    logic [DEPTH-1:0] exp_en;
    bit               exp_in_ready;
    bit               exp_out_valid;
    bit               m_in_fire;
    bit               m_out_fire;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Items slide forward one slot per cycle unless blocked by the item ahead.
    task automatic model_eval(input bit iv, input bit ordy, input bit hd, input bit rs);
        int  lim;
        int  np;
        bit  moving;
        moving        = rs && !hd;
        nxt_q         = {};
        exp_en        = '0;
        exp_out_valid = moving && (pos_q.size() > 0) && (pos_q[0] == DEPTH - 1);
        m_out_fire    = exp_out_valid && ordy;
        lim           = DEPTH;
        for (int j = 0; j < pos_q.size(); j++) begin
            if (!(j == 0 && m_out_fire)) begin
                np = pos_q[j];
                if (moving && (pos_q[j] + 1 < lim)) np = pos_q[j] + 1;
                if (np != pos_q[j]) exp_en[np] = 1'b1;
                nxt_q.push_back(np);
                lim = np;
            end
        end
        exp_in_ready = moving && (m_state != S_DRAIN) && (lim > 0);
        m_in_fire    = exp_in_ready && iv;
        if (m_in_fire) begin
            exp_en[0] = 1'b1;
            nxt_q.push_back(0);
        end
    endtask

    task automatic model_commit(input bit hd, input bit fl, input bit rs);
        bit eff;
        if (!rs) begin
            pos_q.delete();
            m_state = S_IDLE;
            m_pend  = 1'b0;
            m_done  = 1'b0;
            m_in    = '0;
            m_out   = '0;
        end else if (hd) begin
            m_pend = m_pend | fl;
            m_done = 1'b0;
        end else begin
            eff    = fl | m_pend;
            m_pend = 1'b0;
            m_done = 1'b0;
            pos_q  = nxt_q;
            if (m_in_fire) m_in = m_in + 16'd1;
            if (m_out_fire) m_out = m_out + 16'd1;
            case (m_state)
                S_IDLE: begin
                    if (eff && m_in_fire) m_state = S_DRAIN;
                    else if (eff) m_done = 1'b1;
                    else if (m_in_fire) m_state = S_RUN;
                end
                S_RUN: begin
                    if (eff) m_state = S_DRAIN;
                    else if (pos_q.size() == 0) m_state = S_IDLE;
                end
                S_DRAIN: begin
                    if (pos_q.size() == 0) begin
                        m_state = S_IDLE;
                        m_done  = 1'b1;
                    end
                end
                default: m_state = S_IDLE;
            endcase
        end
    endtask

    // One clock cycle: drive, check everything against the model, advance.
    task automatic step(input bit iv, input bit ordy, input bit hd, input bit fl, input bit rs);
        logic [DEPTH-1:0] sv;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.hold      = hd;
        bus.flush     = fl;
        reset         = rs;
        #1;
        model_eval(iv, ordy, hd, rs);
        sv = '0;
        foreach (pos_q[j]) sv[pos_q[j]] = 1'b1;
        chk("in_ready",    32'(bus.in_ready),    32'(exp_in_ready));
        chk("out_valid",   32'(bus.out_valid),   32'(exp_out_valid));
        chk("stage_en",    32'(bus.stage_en),    32'(exp_en));
        chk("stage_valid", 32'(bus.stage_valid), 32'(sv));
        chk("occupancy",   32'(bus.occupancy),   32'(pos_q.size()));
        chk("in_count",    32'(bus.in_count),    32'(m_in));
        chk("out_count",   32'(bus.out_count),   32'(m_out));
        chk("busy",        32'(bus.busy),        32'(m_state != S_IDLE));
        chk("flush_done",  32'(bus.flush_done),  32'(m_done));
        model_commit(hd, fl, rs);
        @(negedge clock);
        if (bus.flush_done) done_seen++;
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        done_seen     = 0;
        m_state       = S_IDLE;
        m_pend        = 1'b0;
        m_done        = 1'b0;
        m_in          = '0;
        m_out         = '0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.hold      = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clock);
        @(negedge clock);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill and stream
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fs_in_count",  32'(bus.in_count),  32'd20);
        chk("fs_out_count", 32'(bus.out_count), 32'd20);
        chk("fs_occ",       32'(bus.occupancy), 32'd0);
        chk("fs_busy",      32'(bus.busy),      32'd0);

        // Backpressure and bubble collapse
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_stage_valid", 32'(bus.stage_valid), 32'h0000_00E0);
        chk("bp_occ",         32'(bus.occupancy),   32'd3);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_full_occ",    32'(bus.occupancy),   32'd8);
        chk("bp_full_ready",  32'(bus.in_ready),    32'd0);
        chk("bp_full_en",     32'(bus.stage_en),    32'd0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("bp_stream_occ",  32'(bus.occupancy),   32'd8);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Flush with a coincident input item
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("fl_occ",   32'(bus.occupancy), 32'd6);
        chk("fl_ready", 32'(bus.in_ready),  32'd0);
        done_seen = 0;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fl_done_pulses", 32'(done_seen), 32'd1);
        chk("fl_busy",        32'(bus.busy),  32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("fl_idle_done", 32'(bus.flush_done), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fl_idle_done_clr", 32'(bus.flush_done), 32'd0);

        // Hold mid-stream with a flush pulsed during hold
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        done_seen = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("hold_drain_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("hold_flush_pulses", 32'(done_seen), 32'd1);

        // Reset while draining a nearly full chain
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_pre_occ",  32'(bus.occupancy), 32'd7);
        chk("rst_pre_busy", 32'(bus.busy),      32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_occ",   32'(bus.occupancy),   32'd0);
        chk("rst_sv",    32'(bus.stage_valid), 32'd0);
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_count", 32'(bus.in_count),    32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_lat_early", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_lat_out", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) != 0);
        end

        // Counter wrap
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 65534; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("wrap_pre", 32'(bus.in_count), 32'h0000_FFFE);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("wrap_in_count", 32'(bus.in_count), 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
